// File: rtl/sdram_arbiter_if.sv
// Command/handshake bundle shared by the two requesters, the arbiter and the SDRAM controller.
// The arbiter connects through the master modport; the requester/controller side uses slave.
interface sdram_arbiter_if #(
  parameter int AW = 27,
  parameter int DW = 16
);
  logic          a_req;
  logic          a_rwn;
  logic [AW-1:0] a_addr;
  logic [DW-1:0] a_wdata;
  logic          a_done;
  logic [DW-1:0] a_rdata;

  logic          b_req;
  logic          b_rwn;
  logic [AW-1:0] b_addr;
  logic [DW-1:0] b_wdata;
  logic          b_done;
  logic [DW-1:0] b_rdata;

  logic          sd_init_done;
  logic          sd_busy;
  logic          sd_ack;
  logic          sd_data_valid;
  logic          sd_write_done;
  logic [DW-1:0] sd_rdata;
  logic          sd_adv;
  logic          sd_rwn;
  logic [AW-1:0] sd_addr;
  logic [DW-1:0] sd_wdata;

  logic          owner;
  logic          arb_busy;

  modport master (
    input  a_req, a_rwn, a_addr, a_wdata,
    input  b_req, b_rwn, b_addr, b_wdata,
    input  sd_init_done, sd_busy, sd_ack, sd_data_valid, sd_write_done, sd_rdata,
    output a_done, a_rdata, b_done, b_rdata,
    output sd_adv, sd_rwn, sd_addr, sd_wdata,
    output owner, arb_busy
  );

  modport slave (
    output a_req, a_rwn, a_addr, a_wdata,
    output b_req, b_rwn, b_addr, b_wdata,
    output sd_init_done, sd_busy, sd_ack, sd_data_valid, sd_write_done, sd_rdata,
    input  a_done, a_rdata, b_done, b_rdata,
    input  sd_adv, sd_rwn, sd_addr, sd_wdata,
    input  owner, arb_busy
  );
endinterface

// File: rtl/sdram_arbiter.sv
// Two-port arbiter/sequencer in front of sdram_controller (port A = FSMC bridge, port B = DMA).
// Define SDRAM_ARB_RR_EN for round-robin on ties; otherwise port A has fixed priority.
module sdram_arbiter #(
  parameter int AW = 27,
  parameter int DW = 16
) (
  input  logic            clk,
  input  logic            nrst,
  sdram_arbiter_if.master bus
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RD, WAIT_WR} state_t;

  state_t        state_q, state_d;
  logic          sd_adv_q, sd_adv_d;
  logic          sd_rwn_q, sd_rwn_d;
  logic [AW-1:0] sd_addr_q, sd_addr_d;
  logic [DW-1:0] sd_wdata_q, sd_wdata_d;
  logic          owner_q, owner_d;
  logic          arb_busy_q, arb_busy_d;
  logic          a_done_q, a_done_d;
  logic          b_done_q, b_done_d;
  logic [DW-1:0] a_rdata_q, a_rdata_d;
  logic [DW-1:0] b_rdata_q, b_rdata_d;

  logic ctrl_ready;
  logic any_req;
  logic grant_b;
  logic cmd_done;

  always_comb begin
    ctrl_ready = bus.sd_init_done & ~bus.sd_busy;
    any_req    = bus.a_req | bus.b_req;
`ifdef SDRAM_ARB_RR_EN
    // On a tie the port that did not own the last operation wins; owner resets to A.
    grant_b    = bus.b_req & (~bus.a_req | ~owner_q);
`else
    grant_b    = ~bus.a_req;
`endif
  end

  always_comb begin
    state_d    = state_q;
    sd_adv_d   = sd_adv_q;
    sd_rwn_d   = sd_rwn_q;
    sd_addr_d  = sd_addr_q;
    sd_wdata_d = sd_wdata_q;
    owner_d    = owner_q;
    a_rdata_d  = a_rdata_q;
    b_rdata_d  = b_rdata_q;
    a_done_d   = 1'b0;
    b_done_d   = 1'b0;
    cmd_done   = 1'b0;

    case (state_q)
      IDLE: begin
        if (ctrl_ready && any_req) begin
          owner_d    = grant_b;
          sd_rwn_d   = grant_b ? bus.b_rwn   : bus.a_rwn;
          sd_addr_d  = grant_b ? bus.b_addr  : bus.a_addr;
          sd_wdata_d = grant_b ? bus.b_wdata : bus.a_wdata;
          sd_adv_d   = 1'b1;
          state_d    = ISSUE;
        end
      end
      ISSUE: begin
        if (bus.sd_ack) begin
          sd_adv_d = 1'b0;
          // A controller may finish in the very cycle it acknowledges.
          if (sd_rwn_q ? bus.sd_data_valid : bus.sd_write_done) begin
            cmd_done = 1'b1;
          end else begin
            state_d = sd_rwn_q ? WAIT_RD : WAIT_WR;
          end
        end
      end
      WAIT_RD: cmd_done = bus.sd_data_valid;
      WAIT_WR: cmd_done = bus.sd_write_done;
      default: state_d = IDLE;
    endcase

    if (cmd_done) begin
      state_d  = IDLE;
      a_done_d = ~owner_q;
      b_done_d = owner_q;
      if (sd_rwn_q) begin
        if (owner_q) begin
          b_rdata_d = bus.sd_rdata;
        end else begin
          a_rdata_d = bus.sd_rdata;
        end
      end
    end

    arb_busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q    <= IDLE;
      sd_adv_q   <= 1'b0;
      sd_rwn_q   <= 1'b0;
      sd_addr_q  <= '0;
      sd_wdata_q <= '0;
      owner_q    <= 1'b0;
      arb_busy_q <= 1'b0;
      a_done_q   <= 1'b0;
      b_done_q   <= 1'b0;
      a_rdata_q  <= '0;
      b_rdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      sd_adv_q   <= sd_adv_d;
      sd_rwn_q   <= sd_rwn_d;
      sd_addr_q  <= sd_addr_d;
      sd_wdata_q <= sd_wdata_d;
      owner_q    <= owner_d;
      arb_busy_q <= arb_busy_d;
      a_done_q   <= a_done_d;
      b_done_q   <= b_done_d;
      a_rdata_q  <= a_rdata_d;
      b_rdata_q  <= b_rdata_d;
    end
  end

  assign bus.sd_adv   = sd_adv_q;
  assign bus.sd_rwn   = sd_rwn_q;
  assign bus.sd_addr  = sd_addr_q;
  assign bus.sd_wdata = sd_wdata_q;
  assign bus.owner    = owner_q;
  assign bus.arb_busy = arb_busy_q;
  assign bus.a_done   = a_done_q;
  assign bus.b_done   = b_done_q;
  assign bus.a_rdata  = a_rdata_q;
  assign bus.b_rdata  = b_rdata_q;
endmodule

// File: tb/tb_sdram_arbiter.sv
// Self-checking bench for sdram_arbiter: directed vector table, corner sequences, then
// randomized traffic against a transaction-level model of the arbitration rules.
module tb_sdram_arbiter;
  localparam int AW = 27;
  localparam int DW = 16;
  localparam int N_RAND = 3000;
`ifdef SDRAM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif
  localparam int PH_IDLE = 0;
  localparam int PH_ISS  = 1;
  localparam int PH_CMP  = 2;
  localparam int PH_DONE = 3;

  logic clk = 1'b0;
  logic nrst;
  always #5 clk = ~clk;

  sdram_arbiter_if #(.AW(AW), .DW(DW)) bus ();
  sdram_arbiter #(.AW(AW), .DW(DW)) dut (.clk(clk), .nrst(nrst), .bus(bus));

  typedef struct {
    logic          port;
    logic          rwn;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    int            ack_dly;
    int            cmp_dly;
    logic [DW-1:0] rdata;
    logic [DW-1:0] exp_a_rdata;
    logic [DW-1:0] exp_b_rdata;
  } vec_t;

  int n_checks = 0;
  int n_errors = 0;
  logic [DW-1:0] exp_a_rd;
  logic [DW-1:0] exp_b_rd;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive_req(input vec_t v);
    if (v.port) begin
      bus.b_req = 1'b1; bus.b_rwn = v.rwn; bus.b_addr = v.addr; bus.b_wdata = v.wdata;
    end else begin
      bus.a_req = 1'b1; bus.a_rwn = v.rwn; bus.a_addr = v.addr; bus.a_wdata = v.wdata;
    end
  endtask

  task automatic drive_cmp(input logic rwn, input logic [DW-1:0] rdata);
    if (rwn) begin
      bus.sd_data_valid = 1'b1; bus.sd_rdata = rdata;
    end else begin
      bus.sd_write_done = 1'b1; bus.sd_rdata = 16'hDEAD;
    end
  endtask

  task automatic clear_cmp();
    bus.sd_data_valid = 1'b0;
    bus.sd_write_done = 1'b0;
    bus.sd_rdata      = 16'hDEAD;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_sd_adv"},   bus.sd_adv,   0);
    chk({tag, "_sd_rwn"},   bus.sd_rwn,   0);
    chk({tag, "_sd_addr"},  bus.sd_addr,  0);
    chk({tag, "_sd_wdata"}, bus.sd_wdata, 0);
    chk({tag, "_a_done"},   bus.a_done,   0);
    chk({tag, "_b_done"},   bus.b_done,   0);
    chk({tag, "_owner"},    bus.owner,    0);
    chk({tag, "_arb_busy"}, bus.arb_busy, 0);
    chk({tag, "_a_rdata"},  bus.a_rdata,  0);
    chk({tag, "_b_rdata"},  bus.b_rdata,  0);
  endtask

  // Waits (bounded) for sd_adv, then checks the latched command against the request.
  task automatic wait_grant(input vec_t v, input string tag);
    int t = 0;
    while (bus.sd_adv !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk({tag, "_grant"},    bus.sd_adv,   1'b1);
    chk({tag, "_owner"},    bus.owner,    v.port);
    chk({tag, "_sd_rwn"},   bus.sd_rwn,   v.rwn);
    chk({tag, "_sd_addr"},  bus.sd_addr,  v.addr);
    if (!v.rwn) chk({tag, "_sd_wdata"}, bus.sd_wdata, v.wdata);
    chk({tag, "_busy_on"},  bus.arb_busy, 1'b1);
  endtask

  // Plays the controller for one command and checks the completion cycle.
  task automatic serve_check(input vec_t v, input string tag);
    repeat (v.ack_dly) begin
      @(negedge clk);
      chk({tag, "_adv_hold"}, bus.sd_adv, 1'b1);
    end
    bus.sd_ack = 1'b1;
    if (v.cmp_dly == 0) drive_cmp(v.rwn, v.rdata);
    @(negedge clk);
    bus.sd_ack = 1'b0;
    clear_cmp();
    chk({tag, "_adv_drop"}, bus.sd_adv, 1'b0);
    if (v.cmp_dly > 0) begin
      chk({tag, "_busy_wait"}, bus.arb_busy, 1'b1);
      chk({tag, "_early_done"}, bus.a_done | bus.b_done, 1'b0);
      repeat (v.cmp_dly - 1) @(negedge clk);
      drive_cmp(v.rwn, v.rdata);
      @(negedge clk);
      clear_cmp();
    end
    if (v.rwn) begin
      if (v.port) exp_b_rd = v.rdata;
      else        exp_a_rd = v.rdata;
    end
    chk({tag, "_a_done"},   bus.a_done,   !v.port);
    chk({tag, "_b_done"},   bus.b_done,   v.port);
    chk({tag, "_busy_off"}, bus.arb_busy, 1'b0);
    chk({tag, "_a_rdata"},  bus.a_rdata,  exp_a_rd);
    chk({tag, "_b_rdata"},  bus.b_rdata,  exp_b_rd);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    string tag;
    tag = $sformatf("vec%0d", idx);
    drive_req(v);
    wait_grant(v, tag);
    serve_check(v, tag);
    chk({tag, "_tbl_a_rdata"}, bus.a_rdata, v.exp_a_rdata);
    chk({tag, "_tbl_b_rdata"}, bus.b_rdata, v.exp_b_rdata);
    if (v.port) bus.b_req = 1'b0;
    else        bus.a_req = 1'b0;
    @(negedge clk);
    chk({tag, "_pulse_end"}, bus.a_done | bus.b_done, 1'b0);
    $display("vec%0d port=%0d rwn=%0d addr=%h a_rdata=%h b_rdata=%h", idx, v.port, v.rwn,
             v.addr, bus.a_rdata, bus.b_rdata);
  endtask

  task automatic new_req(input logic port);
    vec_t v;
    v.port = port; v.rwn = 1'($urandom_range(0, 1));
    v.addr = AW'($urandom); v.wdata = DW'($urandom);
    drive_req(v);
  endtask

  // Random traffic: the model tracks one in-flight operation and predicts every grant
  // from the arbitration rules (ready last cycle, who requested, who owned last).
  task automatic run_random(input int ncyc);
    logic          busy_m, last_own, own_m, rwn_m, rdy_prev, idle_prev;
    logic          exp_grant, win, done_a, done_b;
    logic [AW-1:0] addr_m;
    logic [DW-1:0] wdata_m, rdata_m;
    int            phase, cnt, cmp_dly, n_ops;
    busy_m = 1'b0; last_own = 1'b0; own_m = 1'b0; rwn_m = 1'b0;
    addr_m = '0; wdata_m = '0; rdata_m = '0;
    phase = PH_IDLE; cnt = 0; cmp_dly = 0; n_ops = 0;
    rdy_prev = bus.sd_init_done & ~bus.sd_busy;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      idle_prev = !busy_m;
      done_a = 1'b0; done_b = 1'b0;
      if (phase == PH_DONE) begin
        chk("rnd_a_done", bus.a_done, !own_m);
        chk("rnd_b_done", bus.b_done, own_m);
        chk("rnd_adv_done", bus.sd_adv, 1'b0);
        if (rwn_m) begin
          if (own_m) exp_b_rd = rdata_m;
          else       exp_a_rd = rdata_m;
        end
        if (own_m) done_b = 1'b1;
        else       done_a = 1'b1;
        $display("rnd op%0d port=%0d rwn=%0d addr=%h", n_ops, own_m, rwn_m, addr_m);
        busy_m = 1'b0; phase = PH_IDLE; n_ops++;
      end else begin
        chk("rnd_a_nodone", bus.a_done, 1'b0);
        chk("rnd_b_nodone", bus.b_done, 1'b0);
      end
      chk("rnd_a_rdata", bus.a_rdata, exp_a_rd);
      chk("rnd_b_rdata", bus.b_rdata, exp_b_rd);
      if (phase == PH_ISS) chk("rnd_adv_hold", bus.sd_adv, 1'b1);
      if (phase == PH_CMP) chk("rnd_adv_low", bus.sd_adv, 1'b0);
      if (busy_m) chk("rnd_addr_latched", bus.sd_addr, addr_m);
      if (idle_prev) begin
        exp_grant = rdy_prev && (bus.a_req || bus.b_req);
        chk("rnd_grant", bus.sd_adv, exp_grant);
        if (exp_grant) begin
          if (bus.a_req && bus.b_req) win = RR ? !last_own : 1'b0;
          else                        win = bus.b_req;
          own_m   = win;
          rwn_m   = win ? bus.b_rwn   : bus.a_rwn;
          addr_m  = win ? bus.b_addr  : bus.a_addr;
          wdata_m = win ? bus.b_wdata : bus.a_wdata;
          chk("rnd_owner", bus.owner, own_m);
          chk("rnd_sd_rwn", bus.sd_rwn, rwn_m);
          chk("rnd_sd_addr", bus.sd_addr, addr_m);
          chk("rnd_sd_wdata", bus.sd_wdata, wdata_m);
          last_own = win; busy_m = 1'b1; phase = PH_ISS;
          cnt = $urandom_range(0, 3); cmp_dly = $urandom_range(0, 4);
        end
      end
      chk("rnd_arb_busy", bus.arb_busy, busy_m);

      bus.sd_ack = 1'b0;
      clear_cmp();
      case (phase)
        PH_ISS: begin
          if (cnt == 0) begin
            bus.sd_ack = 1'b1;
            if (cmp_dly == 0) begin
              rdata_m = DW'($urandom); drive_cmp(rwn_m, rdata_m); phase = PH_DONE;
            end else begin
              phase = PH_CMP; cnt = cmp_dly;
            end
          end else begin
            cnt--;
          end
        end
        PH_CMP: begin
          cnt--;
          if (cnt == 0) begin
            rdata_m = DW'($urandom); drive_cmp(rwn_m, rdata_m); phase = PH_DONE;
          end
        end
        default: begin
          // Stray completion strobes while idle must be ignored.
          if ($urandom_range(0, 7) == 0) begin
            if ($urandom_range(0, 1) == 1) bus.sd_data_valid = 1'b1;
            else                           bus.sd_write_done = 1'b1;
            bus.sd_rdata = DW'($urandom);
          end
        end
      endcase

      if (done_a) begin
        if ($urandom_range(0, 1) == 1) new_req(1'b0);
        else                           bus.a_req = 1'b0;
      end else if (!bus.a_req && $urandom_range(0, 3) == 0) begin
        new_req(1'b0);
      end
      if (done_b) begin
        if ($urandom_range(0, 1) == 1) new_req(1'b1);
        else                           bus.b_req = 1'b0;
      end else if (!bus.b_req && $urandom_range(0, 3) == 0) begin
        new_req(1'b1);
      end
      // Disturb the in-flight owner's fields: the latched command must not follow them.
      if (busy_m && $urandom_range(0, 3) == 0) begin
        if (own_m) bus.b_addr = AW'($urandom);
        else       bus.a_addr = AW'($urandom);
      end
      if (!busy_m) begin
        bus.sd_init_done = ($urandom_range(0, 7) != 0);
        bus.sd_busy      = ($urandom_range(0, 3) == 0);
      end
      rdy_prev = bus.sd_init_done & ~bus.sd_busy;
    end
    chk("rnd_enough_ops", n_ops >= 100, 1'b1);
    bus.a_req = 1'b0; bus.b_req = 1'b0;
    bus.sd_ack = 1'b0; clear_cmp();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, limit %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[7];
    vec_t nv, rv, va, vb, v;
    int   a_cnt, b_cnt;
    logic exp_port;

    vecs[0] = '{1'b0, 1'b1, 27'h0001234, 16'h0000, 2, 5, 16'hBEEF, 16'hBEEF, 16'h0000};
    vecs[1] = '{1'b1, 1'b0, 27'h7FFFFFF, 16'hA55A, 3, 2, 16'h0000, 16'hBEEF, 16'h0000};
    vecs[2] = '{1'b0, 1'b1, 27'h0000040, 16'h0000, 0, 0, 16'h0F0F, 16'h0F0F, 16'h0000};
    vecs[3] = '{1'b1, 1'b1, 27'h0000010, 16'h0000, 1, 1, 16'h1234, 16'h0F0F, 16'h1234};
    vecs[4] = '{1'b0, 1'b0, 27'h0000020, 16'hC3C3, 0, 3, 16'h0000, 16'h0F0F, 16'h1234};
    vecs[5] = '{1'b1, 1'b1, 27'h4000000, 16'h0000, 4, 0, 16'h7E81, 16'h0F0F, 16'h7E81};
    vecs[6] = '{1'b0, 1'b1, 27'h1FFFFFF, 16'h0000, 1, 0, 16'h8001, 16'h8001, 16'h7E81};

    bus.a_req = 1'b0; bus.a_rwn = 1'b0; bus.a_addr = '0; bus.a_wdata = '0;
    bus.b_req = 1'b0; bus.b_rwn = 1'b0; bus.b_addr = '0; bus.b_wdata = '0;
    bus.sd_init_done = 1'b1; bus.sd_busy = 1'b0; bus.sd_ack = 1'b0;
    clear_cmp();
    exp_a_rd = '0; exp_b_rd = '0;

    nrst = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    nrst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

    // Controller not ready: no grant until both init_done and !busy.
    nv = '{1'b0, 1'b1, 27'h0000ABC, 16'h0000, 1, 2, 16'h5A5A, 16'h0000, 16'h0000};
    bus.sd_init_done = 1'b0;
    drive_req(nv);
    repeat (4) begin
      @(negedge clk);
      chk("nr_init_adv", bus.sd_adv, 1'b0);
      chk("nr_init_busy", bus.arb_busy, 1'b0);
    end
    bus.sd_init_done = 1'b1; bus.sd_busy = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("nr_busy_adv", bus.sd_adv, 1'b0);
      chk("nr_busy_busy", bus.arb_busy, 1'b0);
    end
    bus.sd_busy = 1'b0;
    @(negedge clk);
    chk("nr_first_grant", bus.sd_adv, 1'b1);
    wait_grant(nv, "nr");
    serve_check(nv, "nr");
    bus.a_req = 1'b0;
    @(negedge clk);
    $display("notready seq a_rdata=%h", bus.a_rdata);

    // Reset while waiting for read data, then a stray data_valid.
    rv = '{1'b1, 1'b1, 27'h0000777, 16'h1111, 0, 9, 16'h0000, 16'h0000, 16'h0000};
    drive_req(rv);
    wait_grant(rv, "rst");
    bus.sd_ack = 1'b1;
    @(negedge clk);
    bus.sd_ack = 1'b0;
    chk("rst_in_wait_busy", bus.arb_busy, 1'b1);
    repeat (2) @(negedge clk);
    nrst = 1'b0;
    bus.a_req = 1'b0; bus.b_req = 1'b0;
    @(negedge clk);
    check_all_zero("rst_mid");
    nrst = 1'b1;
    exp_a_rd = '0; exp_b_rd = '0;
    @(negedge clk);
    bus.sd_data_valid = 1'b1; bus.sd_rdata = 16'hFFFF;
    @(negedge clk);
    clear_cmp();
    chk("rst_stray_a_done", bus.a_done, 1'b0);
    chk("rst_stray_b_done", bus.b_done, 1'b0);
    chk("rst_stray_b_rdata", bus.b_rdata, 16'h0000);
    @(negedge clk);
    chk("rst_stray_done_late", bus.a_done | bus.b_done, 1'b0);
    $display("reset seq owner=%0d arb_busy=%0d", bus.owner, bus.arb_busy);

    // Both ports requesting continuously for six operations.
    a_cnt = 0; b_cnt = 0;
    va = '{1'b0, 1'b1, 27'h0000100, 16'h0000, 0, 1, 16'h0000, 16'h0000, 16'h0000};
    vb = '{1'b1, 1'b1, 27'h0000200, 16'h0000, 0, 1, 16'h0000, 16'h0000, 16'h0000};
    drive_req(va);
    drive_req(vb);
    for (int i = 0; i < 6; i++) begin
      exp_port = RR ? ((i % 2) == 0) : 1'b0;
      v = exp_port ? vb : va;
      v.rdata = 16'h1000 + 16'(i);
      wait_grant(v, $sformatf("tie%0d", i));
      serve_check(v, $sformatf("tie%0d", i));
      $display("tie op%0d owner=%0d addr=%h", i, bus.owner, bus.sd_addr);
      if (exp_port) begin
        b_cnt++; vb.addr = 27'h0000200 + 27'(b_cnt); drive_req(vb);
      end else begin
        a_cnt++; va.addr = 27'h0000100 + 27'(a_cnt); drive_req(va);
      end
    end
    bus.a_req = 1'b0; bus.b_req = 1'b0;
    @(negedge clk);
    chk("tie_pulse_end", bus.a_done | bus.b_done, 1'b0);
    repeat (2) @(negedge clk);

    run_random(N_RAND);
    repeat (4) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
